// File: rtl/btn_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// btn_ctrl_pkg
// Shared types and constants for the button scan controller.
//   state_t   : output FSM state (IDLE, VALID)
//   id_w()    : width of a button index for a given button count
//   DEF_*     : default divider / debounce / long-press settings
// -----------------------------------------------------------------------------
package btn_ctrl_pkg;

    localparam int DEF_DIV_BITS   = 16;
    localparam int DEF_DEB_DEPTH  = 3;
    localparam int DEF_LONG_TICKS = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    // Index width; never below 1 so a 2-button build still has a real port.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_rr_arbiter.sv
// -----------------------------------------------------------------------------
// btn_rr_arbiter
// Combinational round-robin picker. Searches req starting at ptr+1 (mod N)
// upward with wrap and returns the first requesting index.
//   req    [N]    : request vector
//   ptr    [W]    : index granted last time (registered by the parent)
//   gnt_id [W]    : selected index (0 when nothing requests)
//   any           : at least one request is present
// -----------------------------------------------------------------------------
module btn_rr_arbiter
    import btn_ctrl_pkg::*;
#(
    parameter int  N = 4,
    localparam int W = id_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] gnt_id,
    output logic         any
);

    logic [W-1:0] idx;

    always_comb begin
        gnt_id = '0;
        any    = 1'b0;
        idx    = '0;
        // k runs 1..N so ptr itself is considered last.
        for (int k = 1; k <= N; k++) begin
            idx = W'((int'(ptr) + k) % N);
            if (!any && req[idx]) begin
                any    = 1'b1;
                gnt_id = idx;
            end
        end
    end

endmodule

// File: rtl/btn_scan_ctrl.sv
// -----------------------------------------------------------------------------
// btn_scan_ctrl
// Multi-button front end: shared sample tick, per-button debounce with
// hysteresis, press-edge event queue and a round-robin valid/ready event port.
//
// Ports:
//   sysclk       : system clock, all logic on rising edge
//   rst_n        : synchronous active-low reset
//   btn          : raw asynchronous button inputs
//   btn_level    : debounced levels
//   evt_valid    : event available
//   evt_ready    : consumer accepts event
//   evt_id       : index of the button that caused the event
//   evt_long     : event is a long press (always 0 without long-press support)
//   evt_ovf      : one-cycle pulse when a press merges into a pending event
//   dbg_state_o  : output FSM state
//
// Handshake: an event transfers on every rising edge where evt_valid and
// evt_ready are both 1; evt_id/evt_long stay stable while evt_valid is high
// and not yet accepted. evt_valid never drops without a transfer (except reset).
//
// Build option: define BTN_LONGPRESS_EN to add per-button hold counters that
// raise a second, long-press event after LONG_TICKS ticks of continuous hold.
// -----------------------------------------------------------------------------
module btn_scan_ctrl
    import btn_ctrl_pkg::*;
#(
    parameter int  N_BTN      = 4,
    parameter int  DIV_BITS   = DEF_DIV_BITS,
    parameter int  DEB_DEPTH  = DEF_DEB_DEPTH,
    parameter int  LONG_TICKS = DEF_LONG_TICKS,
    localparam int ID_W       = id_w(N_BTN)
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] btn_level,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [ID_W-1:0]  evt_id,
    output logic             evt_long,
    output logic             evt_ovf,
    output state_t           dbg_state_o
);

    if (N_BTN < 2 || N_BTN > 16 || DEB_DEPTH < 2 || DEB_DEPTH > 8 || LONG_TICKS < 1)
    begin : g_param_check
        $error("btn_scan_ctrl: parameter out of range");
    end

    logic [DIV_BITS-1:0]  div_q;
    logic                 tick;
    logic [N_BTN-1:0]     sync1_q, sync2_q;
    logic [DEB_DEPTH-1:0] shreg_q [N_BTN];
    logic [N_BTN-1:0]     level_q, level_d, rise;
    logic [N_BTN-1:0]     pend_q, pend_d, lpend_q, lhit;
    logic [N_BTN-1:0]     gnt_onehot, clr_pend, clr_lpend;
    logic [ID_W-1:0]      gnt_id, ptr_q, evt_id_q;
    logic                 gnt_any, gnt_long, fire, ovf_d;
    state_t               state_q;
    logic                 evt_valid_q, evt_long_q, evt_ovf_q;

    assign tick = &div_q;

    // ---------------- divider, synchronizer, debounce ----------------
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            div_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            for (int i = 0; i < N_BTN; i++) shreg_q[i] <= '0;
        end else begin
            div_q   <= div_q + 1'b1;
            sync1_q <= btn;
            sync2_q <= sync1_q;
            if (tick) begin
                for (int i = 0; i < N_BTN; i++)
                    shreg_q[i] <= {shreg_q[i][DEB_DEPTH-2:0], sync2_q[i]};
            end
            level_q <= level_d;
        end
    end

    // Hysteresis: only a full window of equal samples moves the level.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < N_BTN; i++) begin
            if (&shreg_q[i])       level_d[i] = 1'b1;
            else if (~|shreg_q[i]) level_d[i] = 1'b0;
        end
    end

    assign rise = level_d & ~level_q;

    // ---------------- arbitration ----------------
    btn_rr_arbiter #(.N(N_BTN)) u_arb (
        .req    (pend_q | lpend_q),
        .ptr    (ptr_q),
        .gnt_id (gnt_id),
        .any    (gnt_any)
    );

    // A new grant is taken from IDLE, or on the accept edge in VALID.
    assign fire       = gnt_any & ((state_q == IDLE) | evt_ready);
    assign gnt_onehot = N_BTN'(1) << gnt_id;
    assign clr_pend   = (fire && !gnt_long) ? gnt_onehot : '0;
    assign clr_lpend  = (fire &&  gnt_long) ? gnt_onehot : '0;

    // Set wins over the clearing grant; that case is not an overflow.
    assign pend_d = (pend_q & ~clr_pend) | rise;
    assign ovf_d  = (|(rise & pend_q & ~clr_pend)) | (|(lhit & lpend_q & ~clr_lpend));

`ifdef BTN_LONGPRESS_EN
    localparam int                CNT_W   = $clog2(LONG_TICKS + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(LONG_TICKS);
    localparam logic [CNT_W-1:0]  CNT_HIT = CNT_W'(LONG_TICKS - 1);

    logic [CNT_W-1:0] lcnt_q [N_BTN];

    // The counter saturates at LONG_TICKS, so the hit fires once per hold.
    always_comb begin
        lhit = '0;
        for (int i = 0; i < N_BTN; i++)
            lhit[i] = tick & level_q[i] & (lcnt_q[i] == CNT_HIT);
    end

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            lpend_q <= '0;
            for (int i = 0; i < N_BTN; i++) lcnt_q[i] <= '0;
        end else begin
            lpend_q <= (lpend_q & ~clr_lpend) | lhit;
            for (int i = 0; i < N_BTN; i++) begin
                if (!level_q[i])
                    lcnt_q[i] <= '0;
                else if (tick && lcnt_q[i] != CNT_MAX)
                    lcnt_q[i] <= lcnt_q[i] + 1'b1;
            end
        end
    end

    // Short event of a button drains before its long event.
    assign gnt_long = ~pend_q[gnt_id];
`else
    assign lpend_q  = '0;
    assign lhit     = '0;
    assign gnt_long = 1'b0;
`endif

    // ---------------- output FSM ----------------
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= ID_W'(N_BTN - 1);
            pend_q      <= '0;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            evt_long_q  <= 1'b0;
            evt_ovf_q   <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            evt_ovf_q <= ovf_d;
            case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        state_q     <= VALID;
                        evt_valid_q <= 1'b1;
                        evt_id_q    <= gnt_id;
                        evt_long_q  <= gnt_long;
                        ptr_q       <= gnt_id;
                    end
                end
                VALID: begin
                    if (evt_ready) begin
                        if (gnt_any) begin
                            // back-to-back: next event loads on the accept edge
                            evt_id_q   <= gnt_id;
                            evt_long_q <= gnt_long;
                            ptr_q      <= gnt_id;
                        end else begin
                            state_q     <= IDLE;
                            evt_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    evt_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign btn_level   = level_q;
    assign evt_valid   = evt_valid_q;
    assign evt_id      = evt_id_q;
    assign evt_long    = evt_long_q;
    assign evt_ovf     = evt_ovf_q;
    assign dbg_state_o = state_q;

endmodule
